// File: rtl/mod_sync_ctrl.sv
// mod_sync_ctrl: master end of mod_sync_if. Stages host config, commits it atomically on init
// and aligns the modulator to the re-timed ECAT SYNC0. Debug outputs enabled by MOD_SYNC_DBG_EN.
module mod_sync_ctrl #(
    parameter int CLK_FREQ      = 20480000,
    parameter int REF_CLK_FREQ  = 40000,
    parameter int SETTLE_CYCLES = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ECAT_SYNC0,
    input  logic        CFG_WE,
    input  logic [7:0]  CFG_ADDR,
    input  logic [15:0] CFG_DATA,
    output logic        SYNC,
    output logic        REF_CLK_TICK,
    output logic        MOD_CLK_INIT,
    output logic [15:0] MOD_CLK_CYCLE,
    output logic [15:0] MOD_CLK_DIV,
    output logic [63:0] MOD_CLK_SYNC_TIME_NS,
    output logic        BUSY,
    output logic [15:0] SYNC_CNT,
    output logic        SYNC_MISS
);
    localparam int TICK_DIV = CLK_FREQ / REF_CLK_FREQ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int SW       = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] { IDLE, SETTLE, ARMED, RUN } state_t;

    state_t        state, state_next;
    logic [SW-1:0] settle_cnt, settle_next;
    logic [TW-1:0] tick_cnt;
    logic          sync_ff1, sync_ff2, sync_ff3, s_edge;
    logic          init_req, fwd;
    logic [15:0]   stg_cycle, stg_div;
    logic [63:0]   stg_time;

    assign init_req = CFG_WE && (CFG_ADDR == 8'h00) && CFG_DATA[0];
    assign BUSY     = (state == SETTLE) || (state == ARMED);

    // Two flops for metastability, a third to find the rising edge; s_edge is registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            sync_ff3 <= 1'b0;
            s_edge   <= 1'b0;
        end else begin
            sync_ff1 <= ECAT_SYNC0;
            sync_ff2 <= sync_ff1;
            sync_ff3 <= sync_ff2;
            s_edge   <= sync_ff2 & ~sync_ff3;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stg_cycle <= '0;
            stg_div   <= '0;
            stg_time  <= '0;
        end else if (CFG_WE) begin
            case (CFG_ADDR)
                8'h01:   stg_cycle        <= CFG_DATA;
                8'h02:   stg_div          <= CFG_DATA;
                8'h03:   stg_time[15:0]   <= CFG_DATA;
                8'h04:   stg_time[31:16]  <= CFG_DATA;
                8'h05:   stg_time[47:32]  <= CFG_DATA;
                8'h06:   stg_time[63:48]  <= CFG_DATA;
                default: ;
            endcase
        end
    end

    // An init write overrides everything, including an edge arriving in the same cycle
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        fwd         = 1'b0;
        case (state)
            IDLE:   fwd = s_edge;
            SETTLE: begin
                if (settle_cnt <= SW'(1)) begin
                    state_next  = ARMED;
                    settle_next = '0;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            ARMED: begin
                if (s_edge) begin
                    fwd        = 1'b1;
                    state_next = RUN;
                end
            end
            RUN:     fwd = s_edge;
            default: state_next = IDLE;
        endcase
        if (init_req) begin
            state_next  = SETTLE;
            settle_next = SETTLE_LOAD;
            fwd         = 1'b0;
        end
    end

    // INIT is only cleared once in RUN, so the consumer still sees it high alongside the aligning SYNC
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state                <= IDLE;
            settle_cnt           <= '0;
            SYNC                 <= 1'b0;
            MOD_CLK_INIT         <= 1'b0;
            MOD_CLK_CYCLE        <= '0;
            MOD_CLK_DIV          <= '0;
            MOD_CLK_SYNC_TIME_NS <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            SYNC       <= fwd;
            if (init_req) begin
                MOD_CLK_INIT         <= 1'b1;
                MOD_CLK_CYCLE        <= stg_cycle;
                MOD_CLK_DIV          <= stg_div;
                MOD_CLK_SYNC_TIME_NS <= stg_time;
            end else if (state == RUN) begin
                MOD_CLK_INIT <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (SYNC || (tick_cnt == TICK_LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign REF_CLK_TICK = (tick_cnt == TICK_LAST) && !SYNC;

`ifdef MOD_SYNC_DBG_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SYNC_CNT  <= '0;
            SYNC_MISS <= 1'b0;
        end else begin
            if (fwd) begin
                SYNC_CNT <= SYNC_CNT + 16'd1;
            end
            if (init_req) begin
                SYNC_MISS <= 1'b0;
            end else if ((state == SETTLE) && s_edge) begin
                SYNC_MISS <= 1'b1;
            end
        end
    end
`else
    assign SYNC_CNT  = '0;
    assign SYNC_MISS = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sync_ctrl.sv
// tb_mod_sync_ctrl: directed plus randomized bench for mod_sync_ctrl against a timeline-based
// reference model (TICK_DIV=4, SETTLE_CYCLES=8).
module tb_mod_sync_ctrl;
    localparam int CLK_F    = 4000000;
    localparam int REF_F    = 1000000;
    localparam int SETTLE   = 8;
    localparam int TICK_DIV = CLK_F / REF_F;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ECAT_SYNC0 = 1'b0;
    logic        CFG_WE = 1'b0;
    logic [7:0]  CFG_ADDR = 8'h00;
    logic [15:0] CFG_DATA = 16'h0000;
    logic        SYNC, REF_CLK_TICK, MOD_CLK_INIT, BUSY, SYNC_MISS;
    logic [15:0] MOD_CLK_CYCLE, MOD_CLK_DIV, SYNC_CNT;
    logic [63:0] MOD_CLK_SYNC_TIME_NS;

    int checks = 0;
    int failures = 0;

    // Reference model: edges counted from reset release, events kept as edge timestamps
    int          k, anchor, last_init;
    bit          m_sync, m_tick, m_init, m_any_init, m_synced, m_miss, prev_ecat;
    logic [15:0] m_stg [1:6];
    logic [15:0] m_cycle, m_div, m_sync_cnt;
    logic [63:0] m_time;
    int          due_q[$];
    int          ecat_left, low_run;

    mod_sync_ctrl #(
        .CLK_FREQ(CLK_F),
        .REF_CLK_FREQ(REF_F),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ECAT_SYNC0(ECAT_SYNC0),
        .CFG_WE(CFG_WE),
        .CFG_ADDR(CFG_ADDR),
        .CFG_DATA(CFG_DATA),
        .SYNC(SYNC),
        .REF_CLK_TICK(REF_CLK_TICK),
        .MOD_CLK_INIT(MOD_CLK_INIT),
        .MOD_CLK_CYCLE(MOD_CLK_CYCLE),
        .MOD_CLK_DIV(MOD_CLK_DIV),
        .MOD_CLK_SYNC_TIME_NS(MOD_CLK_SYNC_TIME_NS),
        .BUSY(BUSY),
        .SYNC_CNT(SYNC_CNT),
        .SYNC_MISS(SYNC_MISS)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        k = 0; anchor = 0; last_init = 0;
        m_sync = 0; m_tick = 0; m_init = 0; m_any_init = 0; m_synced = 0; m_miss = 0;
        prev_ecat = 0;
        for (int i = 1; i <= 6; i++) m_stg[i] = 16'h0000;
        m_cycle = '0; m_div = '0; m_time = '0; m_sync_cnt = '0;
        due_q.delete();
    endtask

    // SYNC0 rise seen at edge e acts on the controller at edge e+3
    task automatic model_edge();
        bit s_edge, init, settle, armed, fwd, was_run;
        int d;
        s_edge = 0;
        if (due_q.size() > 0 && due_q[0] == k) begin
            s_edge = 1;
            due_q.delete(0);
        end
        if (ECAT_SYNC0 && !prev_ecat) due_q.push_back(k + 3);
        prev_ecat = ECAT_SYNC0;
        init    = CFG_WE && (CFG_ADDR == 8'h00) && CFG_DATA[0];
        d       = k - last_init;
        settle  = m_any_init && !m_synced && d >= 1 && d <= SETTLE;
        armed   = m_any_init && !m_synced && d > SETTLE;
        was_run = m_any_init && m_synced;
        fwd     = s_edge && !init && !settle;
        m_tick  = (((k - anchor) % TICK_DIV) == TICK_DIV - 1) && !fwd;
        if (init) begin
            m_cycle = m_stg[1];
            m_div   = m_stg[2];
            m_time  = {m_stg[6], m_stg[5], m_stg[4], m_stg[3]};
            m_init = 1; m_any_init = 1; m_synced = 0; m_miss = 0; last_init = k;
        end else begin
            if (was_run) m_init = 0;
            if (fwd && armed) m_synced = 1;
            if (s_edge && settle) m_miss = 1;
        end
        if (CFG_WE && CFG_ADDR >= 8'd1 && CFG_ADDR <= 8'd6) m_stg[int'(CFG_ADDR)] = CFG_DATA;
        if (fwd) begin
            m_sync_cnt = m_sync_cnt + 16'd1;
            anchor = k + 1;
        end
        m_sync = fwd;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_all(input string phase);
        check_output({phase, ".sync"},  64'(SYNC),                 64'(m_sync));
        check_output({phase, ".tick"},  64'(REF_CLK_TICK),         64'(m_tick));
        check_output({phase, ".init"},  64'(MOD_CLK_INIT),         64'(m_init));
        check_output({phase, ".cycle"}, 64'(MOD_CLK_CYCLE),        64'(m_cycle));
        check_output({phase, ".div"},   64'(MOD_CLK_DIV),          64'(m_div));
        check_output({phase, ".time"},  MOD_CLK_SYNC_TIME_NS,      m_time);
        check_output({phase, ".busy"},  64'(BUSY),                 64'(m_any_init && !m_synced));
`ifdef MOD_SYNC_DBG_EN
        check_output({phase, ".sync_cnt"},  64'(SYNC_CNT),  64'(m_sync_cnt));
        check_output({phase, ".sync_miss"}, 64'(SYNC_MISS), 64'(m_miss));
`else
        check_output({phase, ".sync_cnt"},  64'(SYNC_CNT),  64'd0);
        check_output({phase, ".sync_miss"}, 64'(SYNC_MISS), 64'd0);
`endif
    endtask

    task automatic apply_stimulus(input string phase);
        @(posedge CLK);
        k++;
        model_edge();
        #1;
        check_all(phase);
    endtask

    task automatic run(input int n, input string phase);
        for (int i = 0; i < n; i++) apply_stimulus(phase);
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [15:0] data, input string phase);
        CFG_WE = 1'b1; CFG_ADDR = addr; CFG_DATA = data;
        apply_stimulus(phase);
        CFG_WE = 1'b0;
    endtask

    task automatic sync_pulse(input int after, input string phase);
        ECAT_SYNC0 = 1'b1;
        run(4, phase);
        ECAT_SYNC0 = 1'b0;
        run(after, phase);
    endtask

    initial begin
        model_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST = 1'b0;

        run(12, "ticks");

        cfg_write(8'h01, 16'h0FFF, "stage");
        cfg_write(8'h02, 16'h0009, "stage");
        cfg_write(8'h03, 16'h5678, "stage");
        cfg_write(8'h04, 16'h1234, "stage");
        cfg_write(8'h05, 16'h0000, "stage");
        cfg_write(8'h06, 16'h0000, "stage");
        cfg_write(8'h00, 16'h0001, "commit");
        check_output("commit.cycle_const", 64'(MOD_CLK_CYCLE), 64'h0FFF);
        check_output("commit.div_const",   64'(MOD_CLK_DIV),   64'h0009);
        check_output("commit.time_const",  MOD_CLK_SYNC_TIME_NS, 64'h12345678);
        check_output("commit.init_const",  64'(MOD_CLK_INIT),  64'd1);
        check_output("commit.busy_const",  64'(BUSY),          64'd1);
        run(19, "settle");
        sync_pulse(10, "align");
        check_output("align.init_low", 64'(MOD_CLK_INIT), 64'd0);

        cfg_write(8'h00, 16'h0001, "miss");
        run(2, "miss");
        sync_pulse(10, "miss");
        check_output("miss.init_held", 64'(MOD_CLK_INIT), 64'd1);
        sync_pulse(8, "miss_align");

        cfg_write(8'h00, 16'h0001, "reinit");
        run(10, "reinit_armed");
        cfg_write(8'h01, 16'h00FF, "reinit");
        cfg_write(8'h00, 16'h0001, "reinit");
        check_output("reinit.cycle_const", 64'(MOD_CLK_CYCLE), 64'h00FF);
        check_output("reinit.init_const",  64'(MOD_CLK_INIT),  64'd1);
        run(4, "reinit_settle");
        sync_pulse(6, "reinit_boundary");
        sync_pulse(8, "reinit_align");

        ECAT_SYNC0 = 1'b1;
        run(3, "same_cycle");
        CFG_WE = 1'b1; CFG_ADDR = 8'h00; CFG_DATA = 16'h0001;
        apply_stimulus("same_cycle");
        CFG_WE = 1'b0; ECAT_SYNC0 = 1'b0;
        check_output("same_cycle.sync_const", 64'(SYNC), 64'd0);
        check_output("same_cycle.busy_const", 64'(BUSY), 64'd1);
        run(10, "pre_reset");

        #2;
        RST = 1'b1;
        #1;
        check_output("async_rst.init_const",  64'(MOD_CLK_INIT),  64'd0);
        check_output("async_rst.cycle_const", 64'(MOD_CLK_CYCLE), 64'd0);
        check_output("async_rst.busy_const",  64'(BUSY),          64'd0);
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        run(6, "idle");
        sync_pulse(8, "idle_fwd");

        ecat_left = 0;
        low_run = 8;
        for (int i = 0; i < 400; i++) begin
            CFG_WE = 1'b0;
            if (ECAT_SYNC0) begin
                if (ecat_left == 0) begin
                    ECAT_SYNC0 = 1'b0;
                    low_run = 0;
                end
            end else if (low_run >= 3 && $urandom_range(0, 9) == 0) begin
                ECAT_SYNC0 = 1'b1;
                ecat_left = $urandom_range(3, 5);
            end
            if ($urandom_range(0, 5) == 0) begin
                int a;
                a = $urandom_range(0, 9);
                CFG_WE = 1'b1;
                CFG_ADDR = (a == 9) ? 8'hC3 : 8'(a);
                CFG_DATA = 16'($urandom);
            end
            apply_stimulus("random");
            if (ECAT_SYNC0) ecat_left--;
            else low_run++;
        end
        CFG_WE = 1'b0;
        ECAT_SYNC0 = 1'b0;
        run(8, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
